// File: rtl/aximm_pkg.sv
// Shared definitions for the AXI-MM increment checker: base data width and
// checker FSM state encodings.
package aximm_pkg;

    localparam int unsigned AXIMM_BASE_DW = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } chk_state_e;

endpackage

// File: rtl/aximm_chkr_fifo.sv
// Synchronous word buffer for the increment checker with flush, full/empty
// flags and an occupancy count; head word is presented combinationally.
module aximm_chkr_fifo #(
    parameter int unsigned DW    = 40,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Guard against overrun/underrun even if the caller misbehaves.
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == {(AW+1){1'b0}});
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + {{AW{1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{AW{1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/aximm_incr_chkr.sv
// Checks that a stream of words from an increment generator follows seed,
// seed+1, ... for exp_cnt words; buffers input in a small FIFO.
module aximm_incr_chkr
    import aximm_pkg::*;
#(
    parameter int unsigned LEADER_MODE = 1,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  chk_start,
    input  logic [LEADER_MODE*AXIMM_BASE_DW-1:0]  seed_in,
    input  logic [7:0]                            exp_cnt,
    input  logic                                  din_vld,
    input  logic [LEADER_MODE*AXIMM_BASE_DW-1:0]  din,
    output logic                                  chkr_fifo_full,
    output logic                                  done,
    output logic                                  pass,
    output logic [7:0]                            err_cnt,
    output logic [7:0]                            rcv_cnt,
    output logic [LEADER_MODE*AXIMM_BASE_DW-1:0]  first_err_data,
    output logic                                  ovf
);

    localparam int unsigned DW = LEADER_MODE * AXIMM_BASE_DW;
    localparam int unsigned CW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] FULL_CNT = (CW+1)'(FIFO_DEPTH);

    chk_state_e    state_q;
    logic [DW-1:0] exp_q;
    logic [7:0]    exp_cnt_q;
    logic [7:0]    rcv_q;
    logic [7:0]    err_q;
    logic [DW-1:0] ferr_q;
    logic          ovf_q;
    logic          done_q;

    logic [DW-1:0] fifo_head_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW:0]   fifo_count_s;
    logic          push_s;
    logic          pop_s;
    logic          mismatch_s;
    logic          last_pop_s;
    logic          ovf_evt_s;

    // A start pulse takes priority: any coincident write is discarded silently.
    assign push_s     = din_vld & ~fifo_full_s & (state_q != ST_DONE) & ~chk_start;
    assign pop_s      = (state_q == ST_CHECK) & ~fifo_empty_s & ~chk_start;
    assign mismatch_s = pop_s & (fifo_head_s != exp_q);
    assign last_pop_s = pop_s & ((rcv_q + 8'd1) == exp_cnt_q);
    assign ovf_evt_s  = din_vld & ~chk_start & (fifo_full_s | (state_q == ST_DONE));

    aximm_chkr_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (chk_start),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (din),
        .rdata_o (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Checker FSM with compare, counters and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            exp_q     <= '0;
            exp_cnt_q <= 8'd0;
            rcv_q     <= 8'd0;
            err_q     <= 8'd0;
            ferr_q    <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else if (chk_start) begin
            exp_q     <= seed_in;
            exp_cnt_q <= exp_cnt;
            rcv_q     <= 8'd0;
            err_q     <= 8'd0;
            ferr_q    <= '0;
            ovf_q     <= 1'b0;
            if (exp_cnt == 8'd0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
            end else begin
                state_q <= ST_CHECK;
                done_q  <= 1'b0;
            end
        end else begin
            if (ovf_evt_s) begin
                ovf_q <= 1'b1;
            end
            // Expected advances from its own register so one bad word costs one error.
            if (pop_s) begin
                exp_q <= exp_q + {{(DW-1){1'b0}}, 1'b1};
                rcv_q <= rcv_q + 8'd1;
            end
            if (mismatch_s) begin
                if (err_q != 8'hFF) begin
                    err_q <= err_q + 8'd1;
                end
                if (err_q == 8'd0) begin
                    ferr_q <= fifo_head_s;
                end
            end
            case (state_q)
                ST_IDLE:  state_q <= ST_IDLE;
                ST_CHECK: begin
                    if (last_pop_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE:  state_q <= ST_DONE;
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign chkr_fifo_full = (fifo_count_s == FULL_CNT);
    assign done           = done_q;
    assign pass           = done_q & (err_q == 8'd0) & ~ovf_q;
    assign err_cnt        = err_q;
    assign rcv_cnt        = rcv_q;
    assign first_err_data = ferr_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_aximm_incr_chkr.sv
// Directed self-checking bench for aximm_incr_chkr (DW=40, FIFO_DEPTH=8).
module tb_aximm_incr_chkr;

    logic        clk;
    logic        rst_n;
    logic        chk_start;
    logic [39:0] seed_in;
    logic [7:0]  exp_cnt;
    logic        din_vld;
    logic [39:0] din;
    logic        chkr_fifo_full;
    logic        done;
    logic        pass;
    logic [7:0]  err_cnt;
    logic [7:0]  rcv_cnt;
    logic [39:0] first_err_data;
    logic        ovf;

    int total;
    int bad;

    aximm_incr_chkr #(
        .LEADER_MODE (1),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .chk_start      (chk_start),
        .seed_in        (seed_in),
        .exp_cnt        (exp_cnt),
        .din_vld        (din_vld),
        .din            (din),
        .chkr_fifo_full (chkr_fifo_full),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .rcv_cnt        (rcv_cnt),
        .first_err_data (first_err_data),
        .ovf            (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [39:0] s, input logic [7:0] n);
        @(posedge clk); #1;
        chk_start = 1'b1; seed_in = s; exp_cnt = n;
        @(posedge clk); #1;
        chk_start = 1'b0;
    endtask

    // Leaves the clock at posedge+1 with din_vld low, so repeated calls are back-to-back.
    task automatic push(input logic [39:0] w);
        din_vld = 1'b1; din = w;
        @(posedge clk); #1;
        din_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_full"}, {63'd0, chkr_fifo_full}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_pass"}, {63'd0, pass}, 64'd0);
        chk({tag, "_err"}, {56'd0, err_cnt}, 64'd0);
        chk({tag, "_rcv"}, {56'd0, rcv_cnt}, 64'd0);
        chk({tag, "_ferr"}, {24'd0, first_err_data}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; chk_start = 1'b0; seed_in = 40'd0; exp_cnt = 8'd0;
        din_vld = 1'b0; din = 40'd0;
        #3;
        check_all_zero("rst");
        @(posedge clk); #1; rst_n = 1'b1;

        // IDLE hold: words are buffered, none popped; 9th write overflows.
        for (int i = 0; i < 8; i++) push(40'h100 + 40'(i));
        chk("idle_full8", {63'd0, chkr_fifo_full}, 64'd1);
        chk("idle_ovf8", {63'd0, ovf}, 64'd0);
        chk("idle_rcv", {56'd0, rcv_cnt}, 64'd0);
        push(40'h108);
        chk("idle_ovf9", {63'd0, ovf}, 64'd1);
        chk("idle_full9", {63'd0, chkr_fifo_full}, 64'd1);
        chk("idle_pass", {63'd0, pass}, 64'd0);

        // Start flushes buffer and clears flags.
        start(40'h00_0000_0010, 8'd16);
        chk("flush_full", {63'd0, chkr_fifo_full}, 64'd0);
        chk("flush_ovf", {63'd0, ovf}, 64'd0);
        for (int i = 0; i < 16; i++) push(40'h10 + 40'(i));
        wait_done("inc16");
        chk("inc16_pass", {63'd0, pass}, 64'd1);
        chk("inc16_rcv", {56'd0, rcv_cnt}, 64'd16);
        chk("inc16_err", {56'd0, err_cnt}, 64'd0);

        // Wrap from all-ones to zero is not an error.
        start(40'hFF_FFFF_FFFE, 8'd4);
        push(40'hFF_FFFF_FFFE);
        push(40'hFF_FFFF_FFFF);
        push(40'h00_0000_0000);
        push(40'h00_0000_0001);
        wait_done("wrap");
        chk("wrap_pass", {63'd0, pass}, 64'd1);
        chk("wrap_err", {56'd0, err_cnt}, 64'd0);
        chk("wrap_rcv", {56'd0, rcv_cnt}, 64'd4);

        // One corrupted word (index 3 expected 0x8, sent 0x99) yields one error.
        start(40'h5, 8'd8);
        push(40'h5); push(40'h6); push(40'h7); push(40'h99);
        push(40'h9); push(40'hA); push(40'hB); push(40'hC);
        wait_done("bad");
        chk("bad_err", {56'd0, err_cnt}, 64'd1);
        chk("bad_ferr", {24'd0, first_err_data}, 64'h99);
        chk("bad_pass", {63'd0, pass}, 64'd0);
        chk("bad_rcv", {56'd0, rcv_cnt}, 64'd8);

        // exp_cnt==0 completes immediately; a later write in DONE overflows.
        start(40'h1234, 8'd0);
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_pass", {63'd0, pass}, 64'd1);
        push(40'h1234);
        chk("done_wr_ovf", {63'd0, ovf}, 64'd1);
        chk("done_wr_pass", {63'd0, pass}, 64'd0);

        // Start coincident with a write: word discarded, no overflow.
        @(posedge clk); #1;
        chk_start = 1'b1; seed_in = 40'h7; exp_cnt = 8'd2;
        din_vld = 1'b1; din = 40'hAAA;
        @(posedge clk); #1;
        chk_start = 1'b0; din_vld = 1'b0;
        chk("coinc_ovf", {63'd0, ovf}, 64'd0);
        push(40'h7); push(40'h8);
        wait_done("coinc");
        chk("coinc_pass", {63'd0, pass}, 64'd1);

        // Reset mid-check abandons everything at once.
        start(40'h0, 8'd16);
        for (int i = 0; i < 16; i++) begin
            if (rcv_cnt == 8'd5) break;
            push(40'(i));
        end
        chk("mid_rcv5", {56'd0, rcv_cnt}, 64'd5);
        #2; rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1; rst_n = 1'b1;
        start(40'h20, 8'd3);
        push(40'h20); push(40'h21); push(40'h22);
        wait_done("fresh");
        chk("fresh_pass", {63'd0, pass}, 64'd1);
        chk("fresh_rcv", {56'd0, rcv_cnt}, 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
